// File: rtl/addsub_pipe.sv
// Pipelined add/sub/accumulate unit with valid/ready handshake and an architectural accumulator.
// Results emerge STAGES cycles after acceptance; the whole pipe stalls under output backpressure.
module addsub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero,
    output logic [WIDTH-1:0] Acc
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAcc = 2'b10,
        OpClr = 2'b11
    } op_e;

    logic             adv;
    logic             accept;
    logic [WIDTH:0]   ext_res;
    logic [WIDTH-1:0] res_sum;
    logic             res_c;
    logic             res_v;
    logic             res_z;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] z_q;

    assign adv      = !vld_q[STAGES-1] || Out_Ready;
    assign In_Ready = adv;
    assign accept   = In_Valid && adv;

    // All arithmetic in WIDTH+1 bits so the top bit is the unsigned carry.
    always_comb begin
        ext_res = '0;
        res_v   = 1'b0;
        case (op_e'(Op))
            OpAdd: begin
                ext_res = {1'b0, A} + {1'b0, B};
                res_v   = (A[MSB] == B[MSB]) && (ext_res[MSB] != A[MSB]);
            end
            OpSub: begin
                ext_res = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                res_v   = (A[MSB] != B[MSB]) && (ext_res[MSB] != A[MSB]);
            end
            OpAcc: begin
                ext_res = {1'b0, acc_q} + {1'b0, A};
                res_v   = (acc_q[MSB] == A[MSB]) && (ext_res[MSB] != acc_q[MSB]);
            end
            default: begin
                ext_res = '0;
                res_v   = 1'b0;
            end
        endcase
        res_sum = ext_res[WIDTH-1:0];
        res_c   = ext_res[WIDTH];
        res_z   = (res_sum == '0);
    end

    // Accumulator updates at the accept edge so back-to-back ACC ops chain without a hazard.
    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            if (op_e'(Op) == OpAcc) begin
                acc_d = res_sum;
            end else if (op_e'(Op) == OpClr) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Data only moves behind a valid bit, so an empty output keeps its last result.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            v_q   <= '0;
            z_q   <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                sum_q[i] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= accept;
            if (accept) begin
                sum_q[0] <= res_sum;
                c_q[0]   <= res_c;
                v_q[0]   <= res_v;
                z_q[0]   <= res_z;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    sum_q[i] <= sum_q[i-1];
                    c_q[i]   <= c_q[i-1];
                    v_q[i]   <= v_q[i-1];
                    z_q[i]   <= z_q[i-1];
                end
            end
        end
    end

    assign Out_Valid = vld_q[STAGES-1];
    assign Sum       = sum_q[STAGES-1];
    assign Carry     = c_q[STAGES-1];
    assign Overflow  = v_q[STAGES-1];
    assign Zero      = z_q[STAGES-1];
    assign Acc       = acc_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=8, STAGES=2): directed test-plan steps plus
// random traffic checked every cycle against an arithmetic reference model.
module tb_addsub_pipe;

    localparam int W = 8;
    localparam int S = 2;
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ACC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         In_Valid;
    logic         In_Ready;
    logic [1:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Out_Valid;
    logic         Out_Ready;
    logic [W-1:0] Sum;
    logic         Carry;
    logic         Overflow;
    logic         Zero;
    logic [W-1:0] Acc;

    addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .Sum      (Sum),
        .Carry    (Carry),
        .Overflow (Overflow),
        .Zero     (Zero),
        .Acc      (Acc)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    int           errors = 0;
    int           checks = 0;
    int           accepts = 0;
    int           xfers = 0;
    bit           m_vld [S];
    res_t         m_res [S];
    logic [W-1:0] m_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic on plain integers: unsigned and signed interpretations separately.
    function automatic res_t ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [W-1:0] acc);
        res_t r;
        int   u;
        int   s;
        u = 0;
        s = 0;
        case (op)
            ADD: begin
                u = int'(a) + int'(b);
                s = int'($signed(a)) + int'($signed(b));
            end
            SUB: begin
                u = int'(a) - int'(b);
                s = int'($signed(a)) - int'($signed(b));
            end
            ACC: begin
                u = int'(acc) + int'(a);
                s = int'($signed(acc)) + int'($signed(a));
            end
            default: begin
                u = 0;
                s = 0;
            end
        endcase
        r.sum = u[W-1:0];
        if (op == SUB) r.c = (u >= 0);
        else           r.c = (u >= (1 << W));
        r.v = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
        r.z = (r.sum == '0);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < S; i++) m_vld[i] = 1'b0;
        m_acc   = '0;
        accepts = 0;
        xfers   = 0;
    endtask

    // One clock: drive inputs, check everything at the negedge, then step the model at the posedge.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ordy, output logic took);
        logic exp_ready;
        In_Valid  = v;
        Op        = op;
        A         = a;
        B         = b;
        Out_Ready = ordy;
        @(negedge Clk);
        exp_ready = !m_vld[S-1] || ordy;
        chk("in_ready", In_Ready, exp_ready);
        chk("out_valid", Out_Valid, m_vld[S-1]);
        if (m_vld[S-1]) begin
            chk("sum", Sum, m_res[S-1].sum);
            chk("carry", Carry, m_res[S-1].c);
            chk("overflow", Overflow, m_res[S-1].v);
            chk("zero", Zero, m_res[S-1].z);
        end
        chk("acc", Acc, m_acc);
        @(posedge Clk);
        took = exp_ready && v;
        if (exp_ready) begin
            if (m_vld[S-1]) xfers++;
            for (int i = S - 1; i > 0; i--) begin
                m_vld[i] = m_vld[i-1];
                m_res[i] = m_res[i-1];
            end
            m_vld[0] = v;
            if (v) begin
                m_res[0] = ref_op(op, a, b, m_acc);
                accepts++;
                if (op == ACC) m_acc = m_res[0].sum;
                if (op == CLR) m_acc = '0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++) cyc(1'b0, ADD, '0, '0, 1'b1, t);
    endtask

    initial begin
        logic         t;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           issued;
        int           cnt;
        bit           saw_low;

        Rst_n     = 1'b0;
        In_Valid  = 1'b0;
        Op        = ADD;
        A         = '0;
        B         = '0;
        Out_Ready = 1'b1;
        model_reset();
        #12;
        chk("rst_out_valid", Out_Valid, 1'b0);
        chk("rst_sum", Sum, 8'h00);
        chk("rst_flags", {Carry, Overflow, Zero}, 3'b000);
        chk("rst_acc", Acc, 8'h00);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("rel_in_ready", In_Ready, 1'b1);

        // Signed overflow on ADD, visible after the pipeline latency.
        cyc(1'b1, ADD, 8'h7F, 8'h01, 1'b1, t);
        cyc(1'b0, ADD, '0, '0, 1'b1, t);
        chk("tp_add_vld", Out_Valid, 1'b1);
        chk("tp_add_sum", Sum, 8'h80);
        chk("tp_add_cvz", {Carry, Overflow, Zero}, 3'b010);
        idle(2);

        cyc(1'b1, ADD, 8'hFF, 8'h01, 1'b1, t);
        cyc(1'b1, SUB, 8'h00, 8'h01, 1'b1, t);
        chk("tp_wrap_sum", Sum, 8'h00);
        chk("tp_wrap_cvz", {Carry, Overflow, Zero}, 3'b101);
        cyc(1'b1, SUB, 8'h80, 8'h01, 1'b1, t);
        chk("tp_borrow_sum", Sum, 8'hFF);
        chk("tp_borrow_cvz", {Carry, Overflow, Zero}, 3'b000);
        cyc(1'b0, ADD, '0, '0, 1'b1, t);
        chk("tp_subovf_sum", Sum, 8'h7F);
        chk("tp_subovf_cvz", {Carry, Overflow, Zero}, 3'b110);
        idle(2);

        // Back-to-back accumulation chain.
        cyc(1'b1, CLR, 8'hAA, 8'hAA, 1'b1, t);
        cyc(1'b1, ACC, 8'h10, 8'h00, 1'b1, t);
        chk("tp_clr_z", {Sum, Zero}, {8'h00, 1'b1});
        cyc(1'b1, ACC, 8'h20, 8'h00, 1'b1, t);
        chk("tp_acc1", Sum, 8'h10);
        cyc(1'b1, ACC, 8'hF0, 8'h00, 1'b1, t);
        chk("tp_acc2", Sum, 8'h30);
        cyc(1'b1, ADD, 8'h01, 8'h02, 1'b1, t);
        chk("tp_acc3", {Sum, Carry}, {8'h20, 1'b1});
        chk("tp_acc_val", Acc, 8'h20);
        idle(2);
        chk("tp_acc_after_add", Acc, 8'h20);

        // Five ADDs with a three-cycle output stall in the middle.
        issued  = 0;
        cnt     = 0;
        saw_low = 1'b0;
        ra      = 8'($urandom);
        rb      = 8'($urandom);
        accepts = 0;
        xfers   = 0;
        while (issued < 5 && cnt < 50) begin
            cyc(1'b1, ADD, ra, rb, !(cnt >= 2 && cnt < 5), t);
            if (In_Ready === 1'b0) saw_low = 1'b1;
            if (t) begin
                issued++;
                ra = 8'($urandom);
                rb = 8'($urandom);
            end
            cnt++;
        end
        idle(4);
        chk("stall_issued", issued, 5);
        chk("stall_ready_low", saw_low, 1'b1);
        chk("stall_no_loss", xfers, accepts);

        // Full-rate random stream, then random valid/ready mix.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 1'b1, t);
        end
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
                ($urandom_range(0, 3) != 0), t);
        end
        idle(4);

        // Asynchronous reset with ops in flight and a non-zero accumulator.
        cyc(1'b1, CLR, '0, '0, 1'b1, t);
        cyc(1'b1, ACC, 8'h55, '0, 1'b1, t);
        cyc(1'b1, ADD, 8'h11, 8'h22, 1'b1, t);
        cyc(1'b1, SUB, 8'h40, 8'h03, 1'b1, t);
        chk("pre_rst_acc", Acc, 8'h55);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_out_valid", Out_Valid, 1'b0);
        chk("arst_sum", Sum, 8'h00);
        chk("arst_acc", Acc, 8'h00);
        model_reset();
        In_Valid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("post_rst_ready", In_Ready, 1'b1);
        idle(3);
        chk("post_rst_no_stale", xfers, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined, registered adder/subtractor with a running accumulator.
- Generalises the 4-bit registered adder in four ways: configurable width, configurable latency, add/sub/accumulate/clear modes, and a valid/ready handshake.
- Full carry, signed-overflow and zero flags.
- Sits in the datapath as the arithmetic unit feeding EX-stage results and multi-cycle accumulation ops.

Parameters:
- WIDTH, 32, operand/result width in bits (legal 4..64).
- STAGES, 2, number of pipeline register stages, i.e. latency (legal 1..4).

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst_n  input  1  asynchronous active-low reset.
- In_Valid  input  1  operand/op present.
- In_Ready  output  1  block can accept this cycle.
- Op  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B (ignored for ACC/CLR).
- Out_Valid  output  1  result present at output stage.
- Out_Ready  input  1  consumer takes result this cycle.
- Sum  output  WIDTH  result.
- Carry  output  1  unsigned carry-out; for SUB, 1 = no borrow.
- Overflow  output  1  signed two's-complement overflow.
- Zero  output  1  Sum == 0.
- Acc  output  WIDTH  current accumulator value (architectural, not pipelined).

Behaviour:
- Reset (Rst_n low, asynchronous):
  - all stage valid bits, Out_Valid, Sum, Carry, Overflow, Zero and Acc clear to 0.
  - In_Ready reads 1 once reset is released.
  - Reset mid-operation discards all in-flight results; no output handshake completes for them.
- Advance: Adv = !Out_Valid || Out_Ready.
  - The whole pipe shifts one stage on each posedge where Adv = 1, otherwise everything holds.
  - Bubbles do not collapse.
- In_Ready = Adv (combinational).
- Accept = In_Valid && In_Ready.
- Stage 1 loads the computed result and Accept as its valid bit.
- Computation is combinational from inputs at acceptance, performed in WIDTH+1 bits:
  - ADD: {C,S} = {0,A} + {0,B}; V = (A[msb]==B[msb]) && (S[msb]!=A[msb]).
  - SUB: {C,S} = {0,A} + {0,~B} + 1; V = (A[msb]!=B[msb]) && (S[msb]!=A[msb]).
  - ACC: {C,S} = {0,Acc} + {0,A}; V as ADD with Acc in place of A.
  - CLR: S = 0, C = 0, V = 0.
  - Z = (S == 0), including for CLR.
- Accumulator:
  - On Accept with ACC, Acc <= S.
  - On Accept with CLR, Acc <= 0.
  - Updates at the acceptance edge, so back-to-back ACC ops see each other's results with no hazard.
  - ADD/SUB never modify Acc.
  - Acc wraps modulo 2^WIDTH; overflow is reported only via the flag.
- Latency:
  - Result of an op accepted at edge k is on the outputs, Out_Valid = 1, after edge k+STAGES-1, provided no stalls.
  - STAGES=1 gives single-cycle registered behaviour.
- Throughput: one op per cycle when Out_Ready is held high.
- Backpressure:
  - While Out_Valid && !Out_Ready, outputs and all stages hold stable.
  - In_Ready = 0, and Acc does not change.
- Output transfer occurs on an edge with Out_Valid && Out_Ready.
- Sum/Carry/Overflow/Zero are only meaningful while Out_Valid = 1.
- When empty they hold their last value, or 0 after reset.
- Simultaneous output transfer and input accept in the same cycle is legal and must not drop or duplicate results.

Test Plan (WIDTH=8, STAGES=2):
- ADD A=0x7F, B=0x01, Out_Ready=1 -> two cycles later Out_Valid=1, Sum=0x80, Carry=0, Overflow=1, Zero=0.
- ADD 0xFF+0x01 -> Sum=0x00, Carry=1, Overflow=0, Zero=1. SUB 0x00-0x01 -> Sum=0xFF, Carry=0, Overflow=0. SUB 0x80-0x01 -> Sum=0x7F, Carry=1, Overflow=1.
- CLR, then ACC A=0x10, 0x20, 0xF0 on consecutive cycles -> outputs 0x10, 0x30, 0x20 (Carry=1 on last). Acc=0x20 afterwards; an ADD interleaved leaves Acc unchanged.
- Stream 5 ADDs with Out_Ready held 0 for 3 cycles mid-stream -> In_Ready drops while stalled. All 5 results emerge in order, none lost or duplicated, outputs stable during the stall.
- Streaming at full rate with Out_Ready=1 -> Out_Valid=1 every cycle after the initial latency; accept and transfer occur on the same edges.
- Assert Rst_n=0 asynchronously (off-edge) with 2 ops in flight and Acc=0x55 -> Out_Valid, Sum and Acc read 0 immediately. After release, no stale result appears and In_Ready=1.
